// File: rtl/ula_pkg.sv
// ula_pkg: opcode encodings, FSM state type and a sizing helper shared by ula_seq
// and its multiplier.
package ula_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Ceiling log2; sizes the shift-amount field and the multiplier step counter.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ula_mul_seq.sv
// ula_mul_seq: unsigned shift-add multiplier. A start pulse loads the operands,
// WIDTH iterations follow, then done pulses for one cycle with product stable.
module ula_mul_seq
  import ula_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int              CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [CNT_W-1:0]   cnt;
  logic               running;
  logic [WIDTH:0]     step_sum;

  // Upper half accumulates; the multiplier sits in the lower half and is
  // consumed one bit per step as the whole register shifts right.
  always_comb begin
    step_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
    if (prod_q[0]) begin
      step_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      prod_q  <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mcand_q <= mcand;
        prod_q  <= {{WIDTH{1'b0}}, mplier};
        cnt     <= '0;
        running <= 1'b1;
      end else if (running) begin
        prod_q <= {step_sum, prod_q[WIDTH-1:1]};
        cnt    <= cnt + 1'b1;
        if (cnt == LAST) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  assign product = prod_q;

endmodule

// File: rtl/ula_seq.sv
// ula_seq: sequential 8-op ALU with valid/ready on both sides and held results.
// Define ULA_SEQ_MUL_EN to build the multi-cycle multiply for opcode 111.
module ula_seq
  import ula_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int OP_W  = 3
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             busy
);

  localparam int SH_W = clog2(WIDTH);

  state_t           state, state_nxt;
  logic             accept;
  logic [OP_W-1:0]  op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH:0]   sum_ext, diff_ext;
  logic [WIDTH-1:0] exec_res;
  logic             exec_c, exec_v;

`ifdef ULA_SEQ_MUL_EN
  logic               mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  // Multiplier loads straight from the input bus on the accepting edge.
  assign mul_start = accept && (op == OP_MUL);

  ula_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (iCLK),
    .rst_n   (iRST_N),
    .start   (mul_start),
    .mcand   (a),
    .mplier  (b),
    .done    (mul_done),
    .product (mul_prod)
  );
`endif

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = ST_EXEC;
`ifdef ULA_SEQ_MUL_EN
          if (op == OP_MUL) begin
            state_nxt = ST_MUL;
          end
`endif
        end
      end
      ST_EXEC: state_nxt = ST_DONE;
      ST_MUL: begin
`ifdef ULA_SEQ_MUL_EN
        if (mul_done) begin
          state_nxt = ST_DONE;
        end
`else
        state_nxt = ST_IDLE;
`endif
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (accept) begin
      op_q <= op;
      a_q  <= a;
      b_q  <= b;
    end
  end

  // Carry and borrow come from the extra top bit of the widened sum/difference.
  always_comb begin
    sum_ext  = {1'b0, a_q} + {1'b0, b_q};
    diff_ext = {1'b0, a_q} - {1'b0, b_q};
    exec_res = '0;
    exec_c   = 1'b0;
    exec_v   = 1'b0;
    case (op_q)
      OP_ADD: begin
        exec_res = sum_ext[WIDTH-1:0];
        exec_c   = sum_ext[WIDTH];
        exec_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_ext[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        exec_res = diff_ext[WIDTH-1:0];
        exec_c   = diff_ext[WIDTH];
        exec_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_ext[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: exec_res = a_q & b_q;
      OP_OR:  exec_res = a_q | b_q;
      OP_XOR: exec_res = a_q ^ b_q;
      OP_SLT: exec_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SLL: exec_res = a_q << b_q[SH_W-1:0];
      default: exec_res = '0;
    endcase
  end

  // Results are only written on completion, so they persist after the handshake.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      res    <= '0;
      res_hi <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else if (state == ST_EXEC) begin
      res    <= exec_res;
      res_hi <= '0;
      flag_z <= (exec_res == '0);
      flag_c <= exec_c;
      flag_v <= exec_v;
    end
`ifdef ULA_SEQ_MUL_EN
    else if ((state == ST_MUL) && mul_done) begin
      res    <= mul_prod[WIDTH-1:0];
      res_hi <= mul_prod[2*WIDTH-1:WIDTH];
      flag_z <= (mul_prod == '0);
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: scoreboard bench for ula_seq; directed cases from the test plan
// followed by randomized operations checked against an arithmetic reference model.
module tb_ula_seq;

  localparam int WIDTH  = 4;
  localparam int MOD    = 16;
  localparam int HALF   = 8;
  localparam int SH_MOD = 4;

  logic             iCLK, iRST_N;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a, b, res, res_hi;
  logic             flag_z, flag_c, flag_v, busy;

  typedef struct {
    int res;
    int res_hi;
    int z;
    int c;
    int v;
    int lat;
    int acc_edge;
  } exp_t;

  exp_t scoreboard[$];
  exp_t mon_e;
  int   n_compared   = 0;
  int   n_mismatched = 0;
  int   cycle        = 0;
  int   rise_edge    = 0;
  logic prev_valid   = 1'b0;
  bit   rand_ready   = 1'b0;
  logic ready_fixed  = 1'b1;

  ula_seq #(.WIDTH(WIDTH), .OP_W(3)) dut (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .res_hi    (res_hi),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .busy      (busy)
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  always @(posedge iCLK) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and two's-complement views.
  function automatic exp_t ref_model(input int opc, input int ua, input int ub);
    exp_t e;
    int sa, sbv, s, r, hi;
    sa  = (ua >= HALF) ? ua - MOD : ua;
    sbv = (ub >= HALF) ? ub - MOD : ub;
    r = 0; hi = 0; e.c = 0; e.v = 0; e.lat = 2; e.acc_edge = 0;
    case (opc)
      0: begin
        s   = ua + ub;
        r   = s % MOD;
        e.c = (s >= MOD) ? 1 : 0;
        e.v = ((sa + sbv) >= HALF || (sa + sbv) < -HALF) ? 1 : 0;
      end
      1: begin
        r   = (ua - ub + MOD) % MOD;
        e.c = (ua < ub) ? 1 : 0;
        e.v = ((sa - sbv) >= HALF || (sa - sbv) < -HALF) ? 1 : 0;
      end
      2: r = ua & ub;
      3: r = ua | ub;
      4: r = ua ^ ub;
      5: r = (sa < sbv) ? 1 : 0;
      6: r = (ua * (1 << (ub % SH_MOD))) % MOD;
      default: begin
`ifdef ULA_SEQ_MUL_EN
        s     = ua * ub;
        r     = s % MOD;
        hi    = s / MOD;
        e.lat = WIDTH + 2;
`else
        r = 0;
`endif
      end
    endcase
    e.res    = r;
    e.res_hi = hi;
    e.z      = (r == 0 && hi == 0) ? 1 : 0;
    return e;
  endfunction

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge iCLK);
      #2;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
    end
  end

  // Monitor: pops one expectation per output handshake.
  initial begin
    forever begin
      @(negedge iCLK);
      if (!iRST_N) begin
        prev_valid = 1'b0;
      end else begin
        if (out_valid && !prev_valid) rise_edge = cycle;
        prev_valid = out_valid;
        if (out_valid && out_ready) begin
          checkOutput("expectation_queued", (scoreboard.size() > 0) ? 1 : 0, 1);
          if (scoreboard.size() > 0) begin
            mon_e = scoreboard.pop_front();
            checkOutput("res", int'(res), mon_e.res);
            checkOutput("res_hi", int'(res_hi), mon_e.res_hi);
            checkOutput("flag_z", int'(flag_z), mon_e.z);
            checkOutput("flag_c", int'(flag_c), mon_e.c);
            checkOutput("flag_v", int'(flag_v), mon_e.v);
            checkOutput("latency", rise_edge - mon_e.acc_edge + 1, mon_e.lat);
          end
        end
      end
    end
  end

  // Called and returns 1 time unit after a rising edge.
  task automatic applyStimulus(input int opc, input int ua, input int ub, output bit ok);
    exp_t e;
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge iCLK); #1;
      guard++;
    end
    if (!in_ready) begin
      checkOutput("in_ready_timeout", 0, 1);
      ok = 1'b0;
      return;
    end
    in_valid = 1'b1;
    op = 3'(opc);
    a  = 4'(ua);
    b  = 4'(ub);
    @(posedge iCLK); #1;
    e = ref_model(opc, ua, ub);
    e.acc_edge = cycle;
    scoreboard.push_back(e);
    in_valid = 1'b0;
    ok = 1'b1;
  endtask

  task automatic run_directed(input int opc, input int ua, input int ub);
    exp_t e;
    bit ok;
    e = ref_model(opc, ua, ub);
    applyStimulus(opc, ua, ub, ok);
    if (ok) begin
      for (int i = 0; i < e.lat - 1; i++) begin
        checkOutput("busy_while_running", int'(busy), 1);
        checkOutput("no_early_valid", int'(out_valid), 0);
        @(posedge iCLK); #1;
      end
      checkOutput("valid_at_latency", int'(out_valid), 1);
    end
  endtask

  task automatic check_cleared(input string tag);
    checkOutput({tag, "_in_ready"}, int'(in_ready), 1);
    checkOutput({tag, "_out_valid"}, int'(out_valid), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_res"}, int'(res), 0);
    checkOutput({tag, "_res_hi"}, int'(res_hi), 0);
    checkOutput({tag, "_flags"}, int'({flag_z, flag_c, flag_v}), 0);
  endtask

  initial begin
    exp_t held;
    bit ok;
    int guard;
    iRST_N = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0;
    #2;
    check_cleared("reset");
    @(posedge iCLK); @(posedge iCLK); #1;
    iRST_N = 1'b1;
    @(posedge iCLK); #1;

    run_directed(0, 9, 8);
    run_directed(1, 3, 5);
    run_directed(5, 14, 1);
    run_directed(7, 15, 15);
    run_directed(6, 3, 6);
    run_directed(4, 7, 7);

    // Result held while the consumer stalls; inputs offered meanwhile must be dropped.
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge iCLK); #1;
      guard++;
    end
    ready_fixed = 1'b0;
    applyStimulus(0, 5, 6, ok);
    held = ref_model(0, 5, 6);
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(posedge iCLK); #1;
      guard++;
    end
    for (int i = 0; i < 10; i++) begin
      checkOutput("hold_out_valid", int'(out_valid), 1);
      checkOutput("hold_in_ready", int'(in_ready), 0);
      checkOutput("hold_res", int'(res), held.res);
      in_valid = 1'b1;
      op = 3'($urandom_range(0, 7));
      a  = 4'($urandom_range(0, 15));
      b  = 4'($urandom_range(0, 15));
      @(posedge iCLK); #1;
    end
    in_valid = 1'b0;
    ready_fixed = 1'b1;
    @(posedge iCLK); #1;
    checkOutput("in_ready_after_handshake", int'(in_ready), 1);

    // Asynchronous reset in the middle of an operation.
    applyStimulus(7, 13, 11, ok);
`ifdef ULA_SEQ_MUL_EN
    @(posedge iCLK); #1;
`endif
    #1;
    iRST_N = 1'b0;
    #1;
    check_cleared("midop_reset");
    scoreboard.delete();
    @(posedge iCLK); #1;
    iRST_N = 1'b1;
    run_directed(0, 2, 2);

    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      applyStimulus($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15), ok);
      if (!ok) break;
    end

    guard = 0;
    while (scoreboard.size() > 0 && guard < 200) begin
      @(posedge iCLK); #1;
      guard++;
    end
    checkOutput("scoreboard_drained", scoreboard.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, compared %0d", n_compared);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
